// File: rtl/serial_word_tx_pkg.sv
// Shared types and mod-3 arithmetic for the serial word transmitter and its detector models.
package serial_word_tx_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2
    } tx_state_t;

    // Remainder of (2*rem + b) mod 3; an out-of-range remainder collapses to 0.
    function automatic logic [1:0] mod3_next(input logic [1:0] rem, input logic b);
        logic [1:0] r;
        r = 2'd0;
        case (rem)
            2'd0:    r = b ? 2'd1 : 2'd0;
            2'd1:    r = b ? 2'd0 : 2'd2;
            2'd2:    r = b ? 2'd2 : 2'd1;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/serial_word_tx_mod3_residue_tracker.sv
// Running remainder mod 3 of a bit stream sent MSB first; synchronous clear wins over enable.
module mod3_residue_tracker
    import serial_word_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [1:0] residue,
    output logic [1:0] residue_nxt
);

    assign residue_nxt = mod3_next(residue, bit_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            residue <= 2'd0;
        end else if (clr) begin
            residue <= 2'd0;
        end else if (en) begin
            residue <= residue_nxt;
        end
    end

endmodule

// File: rtl/serial_word_tx.sv
// Bit-serial word transmitter: accept, one clear cycle, then WIDTH bits MSB first with a mod-3 flag.
// Handshake only in IDLE; words offered during CLEAR/SHIFT are dropped, never queued.
module serial_word_tx
    import serial_word_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             frame_clr,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic [1:0]       residue,
    output logic             word_done,
    output logic             div3
);

    localparam int CW = $clog2(WIDTH);

    tx_state_t        state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             run;
    logic             accept;
    logic [1:0]       res_nxt;

    // Keeps in_ready low while reset is asserted even though state already reads IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    assign in_ready = run && (state == IDLE);
    assign accept   = in_ready && in_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            frame_clr <= 1'b0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            word_done <= 1'b0;
            div3      <= 1'b0;
        end else begin
            frame_clr <= 1'b0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg      <= in_data;
                        state     <= CLEAR;
                        frame_clr <= 1'b1;
                    end
                end
                CLEAR: begin
                    state     <= SHIFT;
                    cnt       <= CW'(WIDTH - 1);
                    out_valid <= 1'b1;
                    out_first <= 1'b1;
                    out_bit   <= sreg[WIDTH-1];
                end
                SHIFT: begin
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                    cnt  <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state     <= IDLE;
                        word_done <= 1'b1;
                        div3      <= (res_nxt == 2'd0);
                    end else begin
                        // Registered out_bit stays equal to the shift register MSB.
                        out_valid <= 1'b1;
                        out_bit   <= sreg[WIDTH-2];
                        out_last  <= (cnt == CW'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mod3_residue_tracker u_residue (
        .clk         (clk),
        .rst         (rst),
        .clr         (accept),
        .en          (state == SHIFT),
        .bit_in      (out_bit),
        .residue     (residue),
        .residue_nxt (res_nxt)
    );

endmodule

// File: tb/tb_serial_word_tx.sv
// Randomized self-checking bench for serial_word_tx against an arithmetic mod-3 reference.
module tb_serial_word_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, frame_clr, out_bit, out_valid, out_first, out_last;
    logic [1:0]   residue;
    logic         word_done, div3;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_k = 0;

    serial_word_tx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .frame_clr (frame_clr),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_last  (out_last),
        .residue   (residue),
        .word_done (word_done),
        .div3      (div3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; offers w, follows the whole frame and ends at the negedge of the word_done cycle.
    task automatic send(input logic [W-1:0] w, input bit garbage, input bit hold);
        int n;
        int det;
        int k;
        logic [W-1:0] rx;
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        k = cyc;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        @(negedge clk);
        check("clr_pulse", 32'(frame_clr), 32'd1);
        check("clr_ovld", 32'(out_valid), 32'd0);
        check("clr_rdy", 32'(in_ready), 32'd0);
        check("clr_res", 32'(residue), 32'd0);
        det = 0;
        rx  = '0;
        for (int i = 0; i < W; i++) begin
            @(posedge clk);
            #1;
            if (garbage) begin
                in_valid = 1'($urandom);
                in_data  = W'($urandom);
            end
            @(negedge clk);
            check("bit", 32'(out_bit), 32'(w[W-1-i]));
            check("ovld", 32'(out_valid), 32'd1);
            check("first", 32'(out_first), 32'(i == 0));
            check("last", 32'(out_last), 32'(i == W - 1));
            check("res_prefix", 32'(residue), 32'((int'(w) >> (W - i)) % 3));
            check("shift_rdy", 32'(in_ready), 32'd0);
            check("shift_done", 32'(word_done), 32'd0);
            check("shift_clr", 32'(frame_clr), 32'd0);
            rx  = {rx[W-2:0], out_bit};
            det = (2 * det + int'(out_bit)) % 3;
        end
        if (garbage) in_valid = 1'b0;
        @(negedge clk);
        check("done", 32'(word_done), 32'd1);
        check("div3", 32'(div3), 32'((int'(w) % 3) == 0));
        check("loop_det", 32'(div3), 32'(det == 0));
        check("res_final", 32'(residue), 32'(int'(w) % 3));
        check("rx_word", 32'(rx), 32'(w));
        check("done_ovld", 32'(out_valid), 32'd0);
        check("done_rdy", 32'(in_ready), 32'd1);
        last_k = k;
    endtask

    initial begin
        int k1;
        logic [W-1:0] w;

        rst = 1'b0;
        #23;
        check("rst_rdy", 32'(in_ready), 32'd0);
        check("rst_outs", 32'({frame_clr, out_bit, out_valid, out_first, out_last, word_done, div3}), 32'd0);
        check("rst_res", 32'(residue), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("rel_rdy_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rel_rdy", 32'(in_ready), 32'd1);

        send(8'h09, 1'b0, 1'b0);
        send(8'h0A, 1'b0, 1'b1);
        k1 = last_k;
        send(8'hFF, 1'b0, 1'b0);
        check("b2b_gap", 32'(last_k - k1), 32'(W + 2));
        send(8'h00, 1'b0, 1'b0);
        send(8'h80, 1'b0, 1'b0);

        // Abort 0x55 in its fourth SHIFT cycle.
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("abort_inshift", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_outs", 32'({frame_clr, out_bit, out_valid, out_first, out_last, word_done, div3}), 32'd0);
        check("abort_res", 32'(residue), 32'd0);
        check("abort_rdy", 32'(in_ready), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_nodone", 32'(word_done), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_nodone_rel", 32'(word_done), 32'd0);
        check("abort_rel_rdy", 32'(in_ready), 32'd1);
        send(8'h03, 1'b0, 1'b0);

        repeat (4) begin
            w = W'($urandom);
            send(w, 1'b1, 1'b0);
        end

        for (int v = 0; v < 256; v++) begin
            send(W'(v), 1'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
